// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline.
package pipe_pkg;

  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One valid/data register pair; loads on load_i, clears on rst_i or clear_i.
// Data only follows a valid source so empty slots keep their last payload.
module elastic_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = src_valid_i;
      if (src_valid_i) begin
        data_d = src_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage valid/ready pipeline with bubble collapsing, stall and flush.
// Latency DEPTH cycles unblocked; in_ready follows out_ready through the ready chain.
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             hold;
  logic [CNT_W-1:0] cnt;

  assign hold = stall_i | flush_i;

  // A stage can take a word if it is empty or everything downstream can move.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready_i;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = ~v[i] | rdy[i+1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (g == 0) begin : g_head
      assign src_valid = in_valid_i;
      assign src_data  = in_data_i;
    end else begin : g_body
      assign src_valid = v[g-1];
      assign src_data  = d[g-1];
    end

    elastic_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (flush_i),
      .load_i      (~hold & rdy[g]),
      .src_valid_i (src_valid),
      .src_data_i  (src_data),
      .valid_o     (v[g]),
      .data_o      (d[g])
    );
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
  end

  assign in_ready_o  = ~hold & rdy[0];
  assign out_valid_o = ~hold & v[DEPTH-1];
  assign out_data_o  = d[DEPTH-1];
  assign count_o     = cnt;

endmodule

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised multi-stage pipeline register with per-stage valid bits, valid/ready flow control, bubble collapsing, global stall and synchronous flush. It replaces chains of fixed enable/clear pipeline registers wherever a datapath needs a DEPTH-cycle delay that tolerates downstream back-pressure without losing or duplicating words. The main users are the fetch/decode boundary and multi-cycle execute units in the core.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 2, number of register stages (≥1)
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  freeze all stages; no handshakes this cycle
- flush  in  1  synchronous clear of all stages; no handshakes this cycle
- in_valid  in  1  upstream word valid
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  stage 0 can accept this cycle
- out_valid  out  1  stage DEPTH-1 holds a word
- out_data  out  WIDTH  stage DEPTH-1 payload
- out_ready  in  1  downstream accepts this cycle
- count  out  CNT_W  number of valid stages, 0..DEPTH

## Operation
- Per stage i: registers v[i] and d[i]. Stage 0 is input side; stage DEPTH-1 drives out_valid/out_data.
- Priority each cycle: rst > flush > stall > normal.
- rst or flush: all v[i] ← 0, all d[i] ← 0. in_ready=0 and out_valid=0 combinationally while flush is high.
- stall (no flush): all registers hold. in_ready=0, out_valid=0.
- Normal: ready chain rdy[DEPTH] = out_ready; rdy[i] = ~v[i] | rdy[i+1]. in_ready = rdy[0].
- Stage i loads when rdy[i]=1. Source is in_valid/in_data for i=0 and v[i-1]/d[i-1] otherwise.
  - v[i] ← source valid.
  - d[i] ← source data only when source valid; otherwise d[i] holds.
- Stage i holds (v and d) when rdy[i]=0.
- Bubbles collapse: an empty stage loads even when stages downstream are blocked.
- Handshakes: input accepted iff in_valid & in_ready; output consumed iff out_valid & out_ready. Words exit in arrival order, none dropped or duplicated outside flush.
- count = popcount(v), computed from registers (no dependence on inputs).
- With stall=flush=0, behaviour is independent of in_data when in_valid=0.

## Timing
- Reset values: all v=0, all d=0, so out_valid=0, out_data=0, count=0. in_ready=1 the first cycle after rst deasserts (stall/flush low).
- Latency: a word accepted at edge N is on out_data after edge N+DEPTH-1 when unblocked, i.e. visible for DEPTH cycles after acceptance cycle counted inclusively. For DEPTH=1, it is visible the cycle after acceptance.
- Throughput: 1 word/cycle with out_ready held high.
- Full: all v=1 and out_ready=0 → in_ready=0. Full with out_ready=1 → in_ready=1; the same-cycle accept and consume leave count unchanged.
- Empty: out_valid=0; out_ready is ignored.
- Combinational paths: out_ready→in_ready (through the ready chain), and flush/stall→in_ready/out_valid. There are no combinational paths from data to data.
- flush concurrent with in_valid: the input is dropped and in_ready=0. Upstream must re-present the word after the flush.
- rst mid-stream: all words are lost and the state equals reset state on the next cycle.

## Structure
- pipe_pkg: count-width helper function for CNT_W. No other typedefs are needed.
- Sub-module elastic_stage (WIDTH): one v/d register pair.
  - Inputs: load, src_valid, src_data, clear.
  - Instantiated DEPTH times in a generate loop.
  - The ready chain and popcount live in elastic_pipe.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_data=32'hFFFF_FFFF → out_valid=0, out_data=0, count=0. in_ready=1 after release.
- Streaming, DEPTH=3: inputs 1,2,3,4 on consecutive cycles, out_ready=1 → outputs 1,2,3,4 on consecutive cycles, the first appearing 3 cycles after its acceptance. count peaks at 3.
- Back-pressure: fill with 10,20,30 with out_ready=0 → count=3, in_ready=0. Raise out_ready for 1 cycle with in_valid=1, data 40 → 10 consumed, 40 accepted, count stays 3. Draining then yields 20,30,40.
- Bubble collapse: DEPTH=3, one word 5, out_ready=0 → 5 reaches stage 2 within 3 cycles. A second word 6 then fills stage 1, count=2.
- Flush: pipe holding 7,8 with flush and in_valid=1 (data 9) in the same cycle → in_ready=0, out_valid=0 that cycle. The next cycle has count=0 and out_data=0, and 9 is never output.
- Stall: pipe holding 1,2 with stall=1 for 3 cycles, out_ready=1 → no output, count=2, in_ready=0. After release, 1 then 2 are output.
